montgomery_b: RTL and testbench



---
 rtl/montgomery_b.sv | 98 +++++++++
 tb/tb_montgomery_b.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/montgomery_b.sv
// montgomery_b: iterative 1024-bit radix-2 Montgomery modular multiplier.
// Computes result = in_a * in_b * 2^-1024 mod in_m (in_m odd) over 1026 cycles.
//
// Ports:
//   clk     - system clock, rising edge
//   resetn  - asynchronous active-low reset
//   start   - one-cycle request; operands sampled in the same cycle (IDLE only)
//   in_a    - multiplicand (< in_m)
//   in_b    - multiplier (< in_m)
//   in_m    - odd modulus
//   result  - registered reduced product, held until the next operation loads it
//   done    - one-cycle completion pulse; result valid in that cycle
module montgomery_b (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [1023:0] in_a,
  input  logic [1023:0] in_b,
  input  logic [1023:0] in_m,
  output logic [1023:0] result,
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StLoop, StSub, StDone} state_e;

  state_e        state_q;
  logic [1023:0] a_q;    // shifted right each iteration so a_q[0] is the current bit
  logic [1023:0] b_q;
  logic [1023:0] m_q;
  logic [1025:0] c_q;
  logic [9:0]    cnt_q;

  logic [1026:0] t_add;
  logic [1026:0] t_red;
  logic [1025:0] c_next;
  logic          c_ge_m;
  logic [1023:0] red_val;

  // One interleaved iteration. C < 2M and B < M keep T below 4M, but the extra
  // top bit keeps out-of-contract operands from wrapping into garbage timing.
  always_comb begin
    t_add  = {1'b0, c_q} + (a_q[0] ? {3'b000, b_q} : 1027'd0);
    t_red  = t_add[0] ? (t_add + {3'b000, m_q}) : t_add;
    c_next = 1026'(t_red >> 1);
  end

  // Final conditional subtraction; only the low 1024 bits of C - M matter
  // because the result is below M whenever C >= M and C < 2M.
  always_comb begin
    c_ge_m  = (c_q >= {2'b00, m_q});
    red_val = c_ge_m ? (c_q[1023:0] - m_q) : c_q[1023:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= in_a;
            b_q     <= in_b;
            m_q     <= in_m;
            c_q     <= '0;
            cnt_q   <= '0;
            state_q <= StLoop;
          end
        end
        StLoop: begin
          c_q   <= c_next;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q + 10'd1;
          if (cnt_q == 10'd1023) begin
            state_q <= StSub;
          end
        end
        StSub: begin
          result  <= red_val;
          done    <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_b.sv
// Self-checking bench for montgomery_b. Expected values come from a big-integer
// model: (a*b mod m) followed by 1024 modular halvings (multiplying by 2^-1024).
module tb_montgomery_b;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [1023:0] in_a;
  logic [1023:0] in_b;
  logic [1023:0] in_m;
  logic [1023:0] result;
  logic          done;

  int errors = 0;
  int checks = 0;

  montgomery_b dut (
    .clk   (clk),
    .resetn(resetn),
    .start (start),
    .in_a  (in_a),
    .in_b  (in_b),
    .in_m  (in_m),
    .result(result),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1023:0] rand1024();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [1023:0] ref_mont(input logic [1023:0] a, input logic [1023:0] b,
                                             input logic [1023:0] m);
    logic [2047:0] p;
    logic [2047:0] r;
    logic [1024:0] x;
    p = {1024'd0, a} * {1024'd0, b};
    r = p % {1024'd0, m};
    x = r[1024:0];
    for (int i = 0; i < 1024; i++) begin
      if (x[0]) x = (x + {1'b0, m}) >> 1;
      else      x = x >> 1;
    end
    return x[1023:0];
  endfunction

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed[191:0]=%h expected[191:0]=%h", tag, obs[191:0], exp[191:0]);
    end
  endtask

  // Called at a negedge: start is sampled at the next posedge (cycle 0). Cycle n
  // is the interval ending at edge n; sampling at its negedge. Returns at the
  // negedge of cycle 1027 so a following op's start lands on edge 1027.
  task automatic run_op(input string tag, input logic [1023:0] a, input logic [1023:0] b,
                        input logic [1023:0] m, input bit disturb);
    logic [1023:0] exp;
    int cyc;
    int pulses;
    int first;
    exp    = ref_mont(a, b, m);
    cyc    = 0;
    pulses = 0;
    first  = -1;
    in_a   = a;
    in_b   = b;
    in_m   = m;
    start  = 1'b1;
    while (cyc < 1027) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        pulses++;
        if (first < 0) begin
          first = cyc;
          chk({tag, "_result"}, result, exp);
        end
      end
      if (cyc < 1027) begin
        start = 1'b0;
        if (disturb) begin
          in_a = rand1024();
          in_b = rand1024();
          in_m = rand1024() | 1024'd1;
          if (cyc == 10 || cyc == 1025) start = 1'b1;
        end
      end
    end
    start = 1'b0;
    chk({tag, "_pulses"}, 1024'(pulses), 1024'd1);
    chk({tag, "_latency"}, 1024'(first), 1024'd1026);
    chk({tag, "_done_low"}, {1023'd0, done}, 1024'd0);
    chk({tag, "_held"}, result, exp);
  endtask

  initial begin
    logic [1023:0] m, a, b, ones;
    int pulses;
    ones   = '1;
    resetn = 1'b0;
    start  = 1'b0;
    in_a   = '0;
    in_b   = '0;
    in_m   = '0;
    #12;
    chk("reset_done", {1023'd0, done}, 1024'd0);
    chk("reset_result", result, 1024'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // R = 1 mod (2^1024 - 1): identity and final-subtraction edge
    run_op("identity", 1024'd1, 1024'd5, ones, 1'b0);
    chk("identity_val", result, 1024'd5);
    run_op("subedge", ones - 1024'd1, ones - 1024'd1, ones, 1'b0);
    chk("subedge_val", result, 1024'd1);

    m = rand1024() | 1024'd1 | (1024'd1 << 1023);
    run_op("zero", 1024'd0, rand1024() % m, m, 1'b0);
    chk("zero_val", result, 1024'd0);

    for (int i = 0; i < 3; i++) begin
      m = rand1024() | 1024'd1;
      if (i == 0) m[1023] = 1'b1;
      a = rand1024() % m;
      b = rand1024() % m;
      run_op($sformatf("rand%0d", i), a, b, m, 1'b0);
    end

    // Spurious starts at cycles 10 and 1025, inputs churning; then immediate restart
    m = rand1024() | 1024'd1 | (1024'd1 << 1023);
    run_op("handshake", rand1024() % m, rand1024() % m, m, 1'b1);
    m = rand1024() | 1024'd1 | (1024'd1 << 1022);
    run_op("backtoback", rand1024() % m, rand1024() % m, m, 1'b0);

    // Reset at cycle 500 of an operation
    m = rand1024() | 1024'd1 | (1024'd1 << 1023);
    in_a  = rand1024() % m;
    in_b  = rand1024() % m;
    in_m  = m;
    start = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 500; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) pulses++;
    end
    resetn = 1'b0;
    #1;
    chk("abort_done", {1023'd0, done}, 1024'd0);
    chk("abort_result", result, 1024'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", 1024'(pulses), 1024'd0);

    m = rand1024() | 1024'd1 | (1024'd1 << 1023);
    run_op("after_abort", rand1024() % m, rand1024() % m, m, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
